// File: rtl/tile_dispatcher_pkg.sv
// Shared definitions for the tile dispatcher: default coordinate width, FSM states
// and the integer log2 used to turn power-of-two tile sizes into shift amounts.
package tile_dispatcher_pkg;

    localparam int DEF_WIDTH = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int log2i(input int value);
        int result;
        result = 0;
        while ((1 << (result + 1)) <= value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tile_dispatcher_coord_stepper.sv
// Per-axis coordinate accumulator: latches origin and step on load, advances by
// step << SHIFT, or snaps back to the origin. All sums wrap mod 2^WIDTH.
module coord_stepper
    import tile_dispatcher_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = 3
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_origin,
    input  logic [WIDTH-1:0] load_step,
    input  logic             advance,
    input  logic             reload,
    output logic [WIDTH-1:0] coord,
    output logic [WIDTH-1:0] step_val
);

    logic signed [WIDTH-1:0] r_origin;
    logic signed [WIDTH-1:0] r_step;
    logic signed [WIDTH-1:0] r_coord;
    logic signed [WIDTH-1:0] w_inc;

    assign w_inc = r_step <<< SHIFT;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_origin <= '0;
            r_step   <= '0;
            r_coord  <= '0;
        end else if (load) begin
            r_origin <= load_origin;
            r_step   <= load_step;
            r_coord  <= load_origin;
        end else if (advance) begin
            r_coord  <= r_coord + w_inc;
        end else if (reload) begin
            r_coord  <= r_origin;
        end
    end

    assign coord    = r_coord;
    assign step_val = r_step;

endmodule

// File: rtl/tile_dispatcher.sv
// Walks a frame as TILES_X x TILES_Y tiles and offers one tile per valid/ready transfer.
// Optional macro ABORT_EN adds an `abort` input that ends the frame early.
module tile_dispatcher
    import tile_dispatcher_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TILE_W  = 8,
    parameter int TILE_H  = 8,
    parameter int TILES_X = 80,
    parameter int TILES_Y = 60,
    localparam int CW = (TILES_X > 1) ? $clog2(TILES_X) : 1,
    localparam int RW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1
)(
    input  logic             clock,
    input  logic             reset,
`ifdef ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] view_min_x,
    input  logic [WIDTH-1:0] view_min_y,
    input  logic [WIDTH-1:0] view_dx,
    input  logic [WIDTH-1:0] view_dy,
    output logic [WIDTH-1:0] tile_min_x,
    output logic [WIDTH-1:0] tile_min_y,
    output logic [WIDTH-1:0] tile_dx,
    output logic [WIDTH-1:0] tile_dy,
    output logic [CW-1:0]    tile_col,
    output logic [RW-1:0]    tile_row,
    output logic             tile_valid,
    input  logic             solver_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int SHIFT_X = log2i(TILE_W);
    localparam int SHIFT_Y = log2i(TILE_H);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic w_abort;
    logic w_xfer;
    logic w_col_last;
    logic w_row_last;
    logic w_load;
    logic w_x_step;
    logic w_row_wrap;

`ifdef ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_xfer     = r_valid && solver_ready;
    assign w_col_last = (r_col == CW'(TILES_X - 1));
    assign w_row_last = (r_row == RW'(TILES_Y - 1));
    assign w_load     = (r_state == ST_IDLE) && start;
    assign w_x_step   = w_xfer && !w_col_last;
    assign w_row_wrap = w_xfer && w_col_last && !w_row_last;

    coord_stepper #(.WIDTH(WIDTH), .SHIFT(SHIFT_X)) u_x (
        .clock       (clock),
        .reset       (reset),
        .load        (w_load),
        .load_origin (view_min_x),
        .load_step   (view_dx),
        .advance     (w_x_step),
        .reload      (w_row_wrap),
        .coord       (tile_min_x),
        .step_val    (tile_dx)
    );

    coord_stepper #(.WIDTH(WIDTH), .SHIFT(SHIFT_Y)) u_y (
        .clock       (clock),
        .reset       (reset),
        .load        (w_load),
        .load_origin (view_min_y),
        .load_step   (view_dy),
        .advance     (w_row_wrap),
        .reload      (1'b0),
        .coord       (tile_min_y),
        .step_val    (tile_dy)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ISSUE;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (w_xfer) begin
                        if (!w_col_last) begin
                            r_col <= r_col + 1'b1;
                        end else if (!w_row_last) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    // An abort wins over the last-tile transition; a same-cycle transfer still counts.
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tile_col   = r_col;
    assign tile_row   = r_row;
    assign tile_valid = r_valid;
    assign busy       = r_busy;
    // frame_done is high only while in DONE, so masking it here suppresses it on abort.
    assign frame_done = r_done && !w_abort;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Self-checking bench for tile_dispatcher against a raster-order tile model.
// Build with ABORT_EN defined to also exercise the abort port.
module tb_tile_dispatcher;

    localparam int W  = 27;
    localparam int TX = 4;
    localparam int TY = 2;
    localparam int TW = 8;
    localparam int TH = 8;
    localparam int NT = TX * TY;
    localparam int CWB = 2;
    localparam int RWB = 1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           abort = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   view_min_x = '0;
    logic [W-1:0]   view_min_y = '0;
    logic [W-1:0]   view_dx = '0;
    logic [W-1:0]   view_dy = '0;
    logic [W-1:0]   tile_min_x;
    logic [W-1:0]   tile_min_y;
    logic [W-1:0]   tile_dx;
    logic [W-1:0]   tile_dy;
    logic [CWB-1:0] tile_col;
    logic [RWB-1:0] tile_row;
    logic           tile_valid;
    logic           solver_ready = 1'b0;
    logic           busy;
    logic           frame_done;

    int total = 0;
    int bad   = 0;

    tile_dispatcher #(
        .WIDTH(W), .TILE_W(TW), .TILE_H(TH), .TILES_X(TX), .TILES_Y(TY)
    ) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef ABORT_EN
        .abort        (abort),
`endif
        .start        (start),
        .view_min_x   (view_min_x),
        .view_min_y   (view_min_y),
        .view_dx      (view_dx),
        .view_dy      (view_dy),
        .tile_min_x   (tile_min_x),
        .tile_min_y   (tile_min_y),
        .tile_dx      (tile_dx),
        .tile_dy      (tile_dy),
        .tile_col     (tile_col),
        .tile_row     (tile_row),
        .tile_valid   (tile_valid),
        .solver_ready (solver_ready),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    // Model: tile k sits at column k%TX, row k/TX; origin = view + index * (step * tile size).
    function automatic logic [W-1:0] model_coord(input logic [W-1:0] base, input logic [W-1:0] step,
                                                 input int size, input int index);
        logic [W-1:0] idx;
        logic [W-1:0] sz;
        idx = W'(index);
        sz  = W'(size);
        return base + idx * (step * sz);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({tile_valid, busy, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000", {tile_valid, busy, frame_done});
        end
        total++;
        if ({tile_min_x, tile_min_y, tile_dx, tile_dy, tile_col, tile_row} !== '0) begin
            bad++;
            $display("FAIL reset_fields: got %h want 0",
                     {tile_min_x, tile_min_y, tile_dx, tile_dy, tile_col, tile_row});
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    // mode 0: ready always 1; mode 1: ready one cycle in three; mode 2: random ready.
    task automatic run_frame(input string tag, input logic [W-1:0] vx, input logic [W-1:0] vy,
                             input logic [W-1:0] dx, input logic [W-1:0] dy,
                             input int mode, input bit glitch);
        int idx;
        int cyc;
        int c;
        int r;
        logic [W-1:0] ex;
        logic [W-1:0] ey;
        idx = 0;
        cyc = 0;
        solver_ready = 1'b0;
        view_min_x = vx; view_min_y = vy; view_dx = dx; view_dy = dy;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (idx < NT && cyc < 200) begin
            case (mode)
                0:       solver_ready = 1'b1;
                1:       solver_ready = (cyc % 3 == 0);
                default: solver_ready = 1'($urandom_range(0, 1));
            endcase
            if (glitch && cyc == 2) begin
                start = 1'b1;
                view_min_x = W'($urandom); view_min_y = W'($urandom);
                view_dx = W'($urandom); view_dy = W'($urandom);
            end
            if (glitch && cyc == 3) start = 1'b0;
            c  = idx % TX;
            r  = idx / TX;
            ex = model_coord(vx, dx, TW, c);
            ey = model_coord(vy, dy, TH, r);
            total++;
            if ({tile_valid, busy, frame_done} !== 3'b110) begin
                bad++;
                $display("FAIL %s ctrl tile %0d: got %b want 110", tag, idx, {tile_valid, busy, frame_done});
            end
            total++;
            if (tile_min_x !== ex) begin
                bad++;
                $display("FAIL %s min_x tile %0d: got %h want %h", tag, idx, tile_min_x, ex);
            end
            total++;
            if (tile_min_y !== ey) begin
                bad++;
                $display("FAIL %s min_y tile %0d: got %h want %h", tag, idx, tile_min_y, ey);
            end
            total++;
            if ({tile_dx, tile_dy} !== {dx, dy}) begin
                bad++;
                $display("FAIL %s steps tile %0d: got %h/%h want %h/%h", tag, idx, tile_dx, tile_dy, dx, dy);
            end
            total++;
            if ({tile_col, tile_row} !== {CWB'(c), RWB'(r)}) begin
                bad++;
                $display("FAIL %s col_row tile %0d: got %0d/%0d want %0d/%0d", tag, idx, tile_col, tile_row, c, r);
            end
            if (tile_valid && solver_ready) idx++;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        solver_ready = 1'b0;
        total++;
        if (idx != NT) begin
            bad++;
            $display("FAIL %s timeout: got %0d transfers want %0d", tag, idx, NT);
        end
        total++;
        if ({tile_valid, busy, frame_done} !== 3'b011) begin
            bad++;
            $display("FAIL %s done_pulse: got %b want 011", tag, {tile_valid, busy, frame_done});
        end
        @(negedge clock);
        total++;
        if ({tile_valid, busy, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL %s idle_after: got %b want 000", tag, {tile_valid, busy, frame_done});
        end
    endtask

    task automatic test_basic();
        run_frame("basic", '0, '0, W'(1), W'(1), 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("bp", '0, '0, W'(1), W'(1), 1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame("glitch", '0, '0, W'(1), W'(1), 0, 1'b1);
    endtask

    task automatic test_wrap();
        run_frame("wrap", W'((1 << 26) - 8), W'(5), W'(1), W'(1), 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            run_frame("rand", W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        solver_ready = 1'b1;
        view_min_x = W'(100); view_min_y = W'(200); view_dx = W'(3); view_dy = W'(4);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clock);
        total++;
        if ({tile_col, tile_row} !== {CWB'(3), RWB'(0)}) begin
            bad++;
            $display("FAIL rstmid pos: got %0d/%0d want 3/0", tile_col, tile_row);
        end
        solver_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if ({tile_valid, busy, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid ctrl: got %b want 000", {tile_valid, busy, frame_done});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid quiet: got done=%b busy=%b want 0/0", frame_done, busy);
            end
        end
        run_frame("rstmid_restart", W'(100), W'(200), W'(3), W'(4), 0, 1'b0);
    endtask

`ifdef ABORT_EN
    task automatic test_abort();
        solver_ready = 1'b1;
        view_min_x = '0; view_min_y = '0; view_dx = W'(1); view_dy = W'(1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        solver_ready = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        total++;
        if ({tile_valid, busy, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL abort ctrl: got %b want 000", {tile_valid, busy, frame_done});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (frame_done !== 1'b0) begin
                bad++;
                $display("FAIL abort quiet: got done=%b want 0", frame_done);
            end
        end
        abort = 1'b1;
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort idle: got busy=%b want 0", busy);
        end
        abort = 1'b0;
        run_frame("abort_restart", '0, '0, W'(1), W'(1), 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
